// File: rtl/uart_tx_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_tx_sched                                                 |
// | Purpose  : Transmit scheduler in front of a single UART transmitter.     |
// |            Arbitrates two byte requesters round-robin, inserts an idle   |
// |            gap (in baud ticks) after every frame, watches for a          |
// |            transmitter that never goes busy, and owns the baud select,   |
// |            changing it only while the line is idle.                      |
// | Ports    : clk, rst (async, active-low)                                  |
// |            cfg_valid/cfg_baud_rate -> cfg_ack, baud_rate                 |
// |            req0/data0 -> ack0, req1/data1 -> ack1                        |
// |            baud_tick, tx_busy -> tx_start, tx_data                       |
// |            busy (not idle, combinational), err (busy timeout pulse)      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module uart_tx_sched #(
  parameter int         GAP_TICKS    = 2,
  parameter logic [1:0] BAUD_DEFAULT = 2'b10,
  parameter int         BUSY_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_valid,
  input  logic [1:0] cfg_baud_rate,
  output logic       cfg_ack,
  output logic [1:0] baud_rate,
  input  logic       req0,
  input  logic [7:0] data0,
  output logic       ack0,
  input  logic       req1,
  input  logic [7:0] data1,
  output logic       ack1,
  input  logic       baud_tick,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic       busy,
  output logic       err
);

  localparam int c_gap_w = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  localparam int c_to_w  = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [c_gap_w-1:0] c_gap_load = c_gap_w'(GAP_TICKS);
  localparam logic [c_gap_w-1:0] c_gap_one  = c_gap_w'(1);
  localparam logic [c_to_w-1:0]  c_to_limit = c_to_w'(BUSY_TIMEOUT);
  localparam logic [c_to_w-1:0]  c_to_one   = c_to_w'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CFG       = 3'd1,
    S_START     = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_GAP       = 3'd5
  } state_t;

  state_t             r_state, w_state_nxt;
  logic               r_cfg_pending, w_cfg_pending_nxt;
  logic [1:0]         r_pend_rate, w_pend_rate_nxt;
  logic [1:0]         r_baud_rate, w_baud_rate_nxt;
  logic               r_last_grant, w_last_grant_nxt;
  logic               r_cfg_ack, w_cfg_ack_nxt;
  logic               r_ack0, w_ack0_nxt;
  logic               r_ack1, w_ack1_nxt;
  logic               r_tx_start, w_tx_start_nxt;
  logic [7:0]         r_tx_data, w_tx_data_nxt;
  logic               r_err, w_err_nxt;
  logic [c_gap_w-1:0] r_gap_cnt, w_gap_cnt_nxt;
  logic [c_to_w-1:0]  r_to_cnt, w_to_cnt_nxt;
  logic [c_to_w-1:0]  w_to_inc;
  logic               w_grant_valid;
  logic               w_grant_sel;

  // Round-robin pick: on contention the requester that did not win last
  // time goes; a lone requester always wins.
  always_comb begin
    w_grant_valid = req0 | req1;
    w_grant_sel   = req1;
    if (req0 && req1) begin
      w_grant_sel = ~r_last_grant;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_cfg_pending_nxt = r_cfg_pending;
    w_pend_rate_nxt   = r_pend_rate;
    w_baud_rate_nxt   = r_baud_rate;
    w_last_grant_nxt  = r_last_grant;
    w_cfg_ack_nxt     = 1'b0;
    w_ack0_nxt        = 1'b0;
    w_ack1_nxt        = 1'b0;
    w_tx_start_nxt    = 1'b0;
    w_tx_data_nxt     = r_tx_data;
    w_err_nxt         = 1'b0;
    w_gap_cnt_nxt     = r_gap_cnt;
    w_to_cnt_nxt      = r_to_cnt;
    w_to_inc          = r_to_cnt + c_to_one;

    case (r_state)
      S_IDLE: begin
        // A pending baud change is applied before any new frame starts.
        if (r_cfg_pending) begin
          w_state_nxt = S_CFG;
        end else if (w_grant_valid) begin
          w_last_grant_nxt = w_grant_sel;
          w_tx_data_nxt    = w_grant_sel ? data1 : data0;
          w_ack0_nxt       = ~w_grant_sel;
          w_ack1_nxt       = w_grant_sel;
          w_state_nxt      = S_START;
        end
      end
      S_CFG: begin
        w_baud_rate_nxt   = r_pend_rate;
        w_cfg_pending_nxt = 1'b0;
        w_cfg_ack_nxt     = 1'b1;
        w_state_nxt       = S_IDLE;
      end
      S_START: begin
        w_tx_start_nxt = 1'b1;
        w_to_cnt_nxt   = '0;
        w_state_nxt    = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        // Counter is 0 in the cycle tx_start is high, so err lands
        // exactly BUSY_TIMEOUT cycles after tx_start.
        if (tx_busy) begin
          w_state_nxt = S_WAIT_DONE;
        end else if (w_to_inc == c_to_limit) begin
          w_err_nxt     = 1'b1;
          w_gap_cnt_nxt = c_gap_load;
          w_state_nxt   = S_GAP;
        end else begin
          w_to_cnt_nxt = w_to_inc;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          w_gap_cnt_nxt = c_gap_load;
          w_state_nxt   = S_GAP;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == '0) begin
          w_state_nxt = S_IDLE;
        end else if (baud_tick) begin
          w_gap_cnt_nxt = r_gap_cnt - c_gap_one;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Capture is evaluated last so a request arriving during CFG survives
    // the clear; the newest requested rate always replaces an older one.
    if (cfg_valid) begin
      w_cfg_pending_nxt = 1'b1;
      w_pend_rate_nxt   = cfg_baud_rate;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cfg_pending <= 1'b0;
      r_pend_rate   <= BAUD_DEFAULT;
      r_baud_rate   <= BAUD_DEFAULT;
      r_last_grant  <= 1'b1;
      r_cfg_ack     <= 1'b0;
      r_ack0        <= 1'b0;
      r_ack1        <= 1'b0;
      r_tx_start    <= 1'b0;
      r_tx_data     <= 8'h00;
      r_err         <= 1'b0;
      r_gap_cnt     <= '0;
      r_to_cnt      <= '0;
    end else begin
      r_cfg_pending <= w_cfg_pending_nxt;
      r_pend_rate   <= w_pend_rate_nxt;
      r_baud_rate   <= w_baud_rate_nxt;
      r_last_grant  <= w_last_grant_nxt;
      r_cfg_ack     <= w_cfg_ack_nxt;
      r_ack0        <= w_ack0_nxt;
      r_ack1        <= w_ack1_nxt;
      r_tx_start    <= w_tx_start_nxt;
      r_tx_data     <= w_tx_data_nxt;
      r_err         <= w_err_nxt;
      r_gap_cnt     <= w_gap_cnt_nxt;
      r_to_cnt      <= w_to_cnt_nxt;
    end
  end

  assign cfg_ack   = r_cfg_ack;
  assign baud_rate = r_baud_rate;
  assign ack0      = r_ack0;
  assign ack1      = r_ack1;
  assign tx_start  = r_tx_start;
  assign tx_data   = r_tx_data;
  assign err       = r_err;
  assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_uart_tx_sched                                              |
// | Purpose  : Scoreboard bench for uart_tx_sched. Stimulus pushes expected  |
// |            bytes, ack ids, baud changes and errors into queues; a        |
// |            monitor pops them as the DUT presents outputs. A second       |
// |            instance with GAP_TICKS=0 covers the zero-gap case.           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_uart_tx_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic [1:0] cfg_baud_rate;
  logic       cfg_ack;
  logic [1:0] baud_rate;
  logic       req0, req1, ack0, ack1;
  logic [7:0] data0, data1;
  logic       baud_tick;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       busy, err;

  // zero-gap instance
  logic       b_req0, b_ack0, b_ack1, b_cfg_ack, b_tx_start, b_tx_busy, b_busy, b_err;
  logic [7:0] b_data0, b_tx_data;
  logic [1:0] b_baud_rate;
  logic       zero1 = 1'b0;
  logic [1:0] zero2 = 2'b00;
  logic [7:0] zero8 = 8'h00;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] exp_tx[$];
  int         exp_ack[$];
  logic [1:0] exp_cfg[$];
  int         exp_err[$];

  bit model_en  = 1'b1;
  int busy_len  = 100;
  bit tick_auto = 1'b0;
  int tick_at   = -1;

  uart_tx_sched #(.GAP_TICKS(2), .BAUD_DEFAULT(2'b10), .BUSY_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_baud_rate(cfg_baud_rate), .cfg_ack(cfg_ack), .baud_rate(baud_rate),
    .req0(req0), .data0(data0), .ack0(ack0),
    .req1(req1), .data1(data1), .ack1(ack1),
    .baud_tick(baud_tick), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .busy(busy), .err(err)
  );

  uart_tx_sched #(.GAP_TICKS(0), .BAUD_DEFAULT(2'b10), .BUSY_TIMEOUT(16)) dut0 (
    .clk(clk), .rst(rst),
    .cfg_valid(zero1), .cfg_baud_rate(zero2), .cfg_ack(b_cfg_ack), .baud_rate(b_baud_rate),
    .req0(b_req0), .data0(b_data0), .ack0(b_ack0),
    .req1(zero1), .data1(zero8), .ack1(b_ack1),
    .baud_tick(baud_tick), .tx_start(b_tx_start), .tx_data(b_tx_data), .tx_busy(b_tx_busy),
    .busy(b_busy), .err(b_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transmitter model: busy rises 2 cycles after tx_start, falls busy_len later.
  initial begin
    int rise_cd;
    int fall_cd;
    rise_cd = 0;
    fall_cd = 0;
    tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst) begin
        tx_busy = 1'b0;
        rise_cd = 0;
        fall_cd = 0;
      end else begin
        if (rise_cd > 0) begin
          rise_cd--;
          if (rise_cd == 0) begin
            tx_busy = 1'b1;
            fall_cd = busy_len;
          end
        end else if (fall_cd > 0) begin
          fall_cd--;
          if (fall_cd == 0) tx_busy = 1'b0;
        end
        if (tx_start && model_en) rise_cd = 2;
      end
    end
  end

  // Baud tick source: free-running every 4 cycles, or a single tick at tick_at.
  initial begin
    baud_tick = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      baud_tick = (tick_auto && (cyc % 4 == 0)) || (cyc == tick_at);
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst) begin
      if (tx_start) begin
        check("tx_start expected", exp_tx.size() > 0, 1);
        if (exp_tx.size() > 0) check("tx_data", tx_data, exp_tx.pop_front());
      end
      if (ack0 || ack1) begin
        check("ack onehot", ack0 & ack1, 0);
        check("ack expected", exp_ack.size() > 0, 1);
        if (exp_ack.size() > 0) check("ack id", {31'b0, ack1}, exp_ack.pop_front());
      end
      if (cfg_ack) begin
        check("cfg_ack expected", exp_cfg.size() > 0, 1);
        if (exp_cfg.size() > 0) check("baud on cfg_ack", baud_rate, exp_cfg.pop_front());
      end
      if (err) begin
        check("err expected", exp_err.size() > 0, 1);
        if (exp_err.size() > 0) void'(exp_err.pop_front());
      end
    end
  end

  function automatic bit sig(input int sel);
    case (sel)
      0:       sig = ack0;
      1:       sig = ack1;
      2:       sig = tx_start;
      3:       sig = !busy;
      4:       sig = cfg_ack;
      5:       sig = err;
      6:       sig = !tx_busy;
      7:       sig = tx_busy;
      10:      sig = ack0 | ack1;
      default: sig = 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int max, input string name, output int n);
    bit hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < max) begin
      @(negedge clk);
      n++;
      hit = sig(sel);
    end
    check({name, " seen"}, hit, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic pulse_tick_next();
    tick_at = cyc + 1;
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst = 1'b0; cfg_valid = 1'b0; cfg_baud_rate = 2'b00;
    req0 = 1'b0; req1 = 1'b0; data0 = 8'h00; data1 = 8'h00;
    b_req0 = 1'b0; b_data0 = 8'h00; b_tx_busy = 1'b0;

    // 1: reset values, single request latency, gap exit after 2 ticks
    do_reset();
    check("rst baud_rate", baud_rate, 2'b10);
    check("rst busy", busy, 0);
    check("rst tx_data", tx_data, 8'h00);
    check("rst pulses", {cfg_ack, ack0, ack1, tx_start, err}, 0);
    req0 = 1'b1; data0 = 8'hA5;
    exp_tx.push_back(8'hA5); exp_ack.push_back(0);
    @(negedge clk);
    check("t1 ack0 at +1", ack0, 1);
    req0 = 1'b0;
    @(negedge clk);
    check("t1 tx_start at +2", tx_start, 1);
    check("t1 tx_data at +2", tx_data, 8'hA5);
    wait_for(7, 20, "t1 tx_busy rise", n);
    wait_for(6, 200, "t1 tx_busy fall", n);
    repeat (4) begin
      @(negedge clk);
      check("t1 gap holds without ticks", busy, 1);
    end
    pulse_tick_next();
    check("t1 busy after tick1", busy, 1);
    pulse_tick_next();
    check("t1 busy after tick2", busy, 1);
    @(negedge clk);
    check("t1 busy gap zero", busy, 1);
    @(negedge clk);
    check("t1 idle after gap", busy, 0);

    // 2: both requesting continuously -> 11,22,11,22
    do_reset();
    tick_auto = 1'b1; busy_len = 10;
    req0 = 1'b1; data0 = 8'h11; req1 = 1'b1; data1 = 8'h22;
    exp_tx.push_back(8'h11); exp_tx.push_back(8'h22); exp_tx.push_back(8'h11); exp_tx.push_back(8'h22);
    exp_ack.push_back(0); exp_ack.push_back(1); exp_ack.push_back(0); exp_ack.push_back(1);
    for (int i = 0; i < 4; i++) wait_for(10, 200, "t2 grant", n);
    req0 = 1'b0; req1 = 1'b0;
    wait_for(3, 200, "t2 idle", n);
    tick_auto = 1'b0;

    // 3: cfg during WAIT_DONE and GAP, req1 pending
    do_reset();
    busy_len = 20;
    req0 = 1'b1; data0 = 8'h33;
    exp_tx.push_back(8'h33); exp_ack.push_back(0);
    wait_for(0, 5, "t3 ack0", n);
    req0 = 1'b0;
    wait_for(7, 20, "t3 tx_busy rise", n);
    @(negedge clk);
    cfg_valid = 1'b1; cfg_baud_rate = 2'b01;
    @(negedge clk);
    cfg_valid = 1'b0;
    check("t3 baud held in WAIT_DONE", baud_rate, 2'b10);
    wait_for(6, 40, "t3 tx_busy fall", n);
    @(negedge clk);
    req1 = 1'b1; data1 = 8'h44;
    cfg_valid = 1'b1; cfg_baud_rate = 2'b11;
    exp_cfg.push_back(2'b11); exp_ack.push_back(1); exp_tx.push_back(8'h44);
    @(negedge clk);
    cfg_valid = 1'b0;
    check("t3 baud held in GAP", baud_rate, 2'b10);
    pulse_tick_next();
    check("t3 baud held tick1", baud_rate, 2'b10);
    pulse_tick_next();
    check("t3 baud held tick2", baud_rate, 2'b10);
    @(negedge clk);
    check("t3 no early ack/cfg", {cfg_ack, ack1, baud_rate}, {2'b00, 2'b10});
    wait_for(4, 10, "t3 cfg_ack", n);
    check("t3 cfg_ack latency", n, 3);
    check("t3 baud applied", baud_rate, 2'b11);
    @(negedge clk);
    check("t3 ack1 after cfg_ack", ack1, 1);
    req1 = 1'b0;
    tick_auto = 1'b1;
    wait_for(3, 300, "t3 idle", n);
    tick_auto = 1'b0;

    // 4: transmitter never busy -> err 16 cycles after tx_start
    do_reset();
    model_en = 1'b0; tick_auto = 1'b1;
    req0 = 1'b1; data0 = 8'h55;
    exp_tx.push_back(8'h55); exp_ack.push_back(0); exp_err.push_back(1);
    wait_for(0, 5, "t4 ack0", n);
    req0 = 1'b0;
    wait_for(2, 5, "t4 tx_start", n);
    wait_for(5, 40, "t4 err", n);
    check("t4 err latency", n, 16);
    wait_for(3, 100, "t4 idle", n);
    model_en = 1'b1;
    req1 = 1'b1; data1 = 8'h66;
    exp_tx.push_back(8'h66); exp_ack.push_back(1);
    wait_for(1, 5, "t4 ack1 after err", n);
    req1 = 1'b0;
    wait_for(3, 300, "t4 idle again", n);
    tick_auto = 1'b0;

    // 5: reset in WAIT_DONE with a pending cfg
    do_reset();
    busy_len = 50;
    req0 = 1'b1; data0 = 8'h77;
    exp_tx.push_back(8'h77); exp_ack.push_back(0);
    wait_for(0, 5, "t5 ack0", n);
    req0 = 1'b0;
    wait_for(7, 20, "t5 tx_busy rise", n);
    @(negedge clk);
    cfg_valid = 1'b1; cfg_baud_rate = 2'b01;
    @(negedge clk);
    cfg_valid = 1'b0;
    check("t5 busy before reset", busy, 1);
    rst = 1'b0;
    #1;
    check("t5 async busy", busy, 0);
    check("t5 async tx_data", tx_data, 8'h00);
    check("t5 async baud", baud_rate, 2'b10);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check("t5 quiet after reset", {busy, cfg_ack}, 0);
    end
    check("t5 baud after reset", baud_rate, 2'b10);

    // 6: zero-gap instance, back-to-back req0
    b_req0 = 1'b1; b_data0 = 8'h81;
    @(negedge clk);
    check("t6 ack0 at +1", b_ack0, 1);
    b_data0 = 8'h82;
    @(negedge clk);
    check("t6 tx_start", b_tx_start, 1);
    check("t6 tx_data 1", b_tx_data, 8'h81);
    b_tx_busy = 1'b1;
    repeat (5) @(negedge clk);
    b_tx_busy = 1'b0;
    @(negedge clk);
    check("t6 gap cycle", {b_ack0, b_busy}, 2'b01);
    @(negedge clk);
    check("t6 idle cycle", {b_ack0, b_busy}, 2'b00);
    @(negedge clk);
    check("t6 second ack", b_ack0, 1);
    b_req0 = 1'b0;
    @(negedge clk);
    check("t6 tx_data 2", {b_tx_start, b_tx_data}, {1'b1, 8'h82});
    b_tx_busy = 1'b1;
    repeat (3) @(negedge clk);
    b_tx_busy = 1'b0;
    repeat (3) @(negedge clk);
    check("t6 final idle", {b_busy, b_err}, 0);

    check("tx queue drained", exp_tx.size(), 0);
    check("ack queue drained", exp_ack.size(), 0);
    check("cfg queue drained", exp_cfg.size(), 0);
    check("err queue drained", exp_err.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d failures %0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Scheduler in front of the UART transmit path.
- Shares one transmitter between two byte requesters using round-robin arbitration.
- Enforces a configurable inter-frame gap, counted in baud ticks.
- Owns the baud_rate select driven to the BaudGenT/BaudGenR pair. Baud changes are applied only while the line is idle, so no frame is corrupted mid-character.

Parameters:
- GAP_TICKS, 2, idle baud ticks inserted after each frame. 0 means no gap.
- BAUD_DEFAULT, 2'b10, baud_rate value after reset.
- BUSY_TIMEOUT, 16, clk cycles to wait for tx_busy to rise after tx_start before declaring an error.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- cfg_valid  in  1  one-cycle strobe requesting a baud change
- cfg_baud_rate  in  2  requested baud select, sampled when cfg_valid=1
- cfg_ack  out  1  one-cycle pulse when the new baud_rate takes effect
- baud_rate  out  2  select to the baud generators
- req0  in  1  requester 0 has a byte (level)
- data0  in  8  requester 0 byte; stable while req0=1
- ack0  out  1  one-cycle pulse when data0 is accepted
- req1  in  1  requester 1 has a byte (level)
- data1  in  8  requester 1 byte; stable while req1=1
- ack1  out  1  one-cycle pulse when data1 is accepted
- baud_tick  in  1  one-clk-wide pulse per bit time, already synchronous to clk
- tx_start  out  1  one-cycle start pulse to the transmitter
- tx_data  out  8  byte to transmit; held from ack until the next grant
- tx_busy  in  1  transmitter busy
- busy  out  1  scheduler not in IDLE
- err  out  1  one-cycle pulse on busy timeout

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - state=IDLE, baud_rate=BAUD_DEFAULT
  - cfg_pending=0, last_grant=1 (so requester 0 wins first)
  - all pulses=0, tx_data=0, busy=0
- Reset mid-frame abandons the frame silently, and any pending cfg is discarded.
- Config capture:
  - cfg_valid=1 in any state latches cfg_baud_rate into pend_rate and sets cfg_pending.
  - A later cfg_valid before it is applied overwrites pend_rate; only the last value is applied, with one cfg_ack.
- IDLE:
  - If cfg_pending=1: go to CFG. Config has priority over requests.
  - Else if req0 or req1: grant one requester, latch its data into tx_data, pulse the matching ack, update last_grant, go to START.
  - Grant rule when both request: the requester not equal to last_grant wins. With a single request, that requester wins regardless of last_grant.
- CFG (one cycle):
  - baud_rate<=pend_rate, cfg_pending<=0, cfg_ack pulses, return to IDLE.
  - A cfg_valid arriving in the same cycle re-sets cfg_pending (capture wins over clear).
- START: tx_start=1 for exactly one cycle; clear the timeout counter; go to WAIT_BUSY.
- WAIT_BUSY:
  - tx_busy=1: go to WAIT_DONE.
  - Counter reaching BUSY_TIMEOUT with tx_busy still 0: pulse err, go to GAP.
- WAIT_DONE: tx_busy=0 -> go to GAP, load gap counter with GAP_TICKS.
- GAP:
  - Counter==0: go to IDLE. This is immediate when GAP_TICKS=0.
  - Otherwise decrement on each baud_tick.
  - baud_tick ignored in all other states.
- Latency (cycles relative to the edge that sees req in IDLE with no pending cfg):
  - ack high in cycle +1.
  - tx_start high in cycle +2.
  - First possible next grant: one cycle after GAP exits.
- Requester handshake:
  - A requester holding req high after ack is treated as a new byte and re-arbitrated in the next IDLE.
  - Dropping req before ack withdraws the request with no side effects.
- Outputs:
  - busy = (state != IDLE); combinational from state.
  - All other outputs are registered.
- Gap counter width: clog2(GAP_TICKS+1), minimum 1. Timeout counter width: clog2(BUSY_TIMEOUT+1).

Test Plan:
- Reset release, req0=1 with data0=8'hA5, tx_busy model rising 2 cycles after tx_start and falling 100 cycles later, GAP_TICKS=2 -> baud_rate=2'b10 after reset; ack0 at +1, tx_start with tx_data=A5 at +2; IDLE reached after the 2nd baud_tick following tx_busy fall.
- req0 and req1 held high continuously, data0=8'h11, data1=8'h22 -> transmitted sequence 11,22,11,22; acks alternate; no requester granted twice in a row.
- cfg_valid with 2'b01 pulsed while in WAIT_DONE, then cfg_valid with 2'b11 pulsed in GAP, with req1 pending -> baud_rate stays 2'b10 until GAP exits; then CFG applies 2'b11 with one cfg_ack; req1 is acked the cycle after.
- tx_busy tied 0, BUSY_TIMEOUT=16 -> err pulses 16 cycles after tx_start, then GAP/IDLE; the next request is still served.
- rst asserted low during WAIT_DONE with cfg_pending set -> outputs go to reset values immediately; after release, no cfg_ack and baud_rate=2'b10.
- GAP_TICKS=0 with back-to-back req0 -> second ack occurs one cycle after tx_busy falls plus the GAP cycle, with no baud_tick dependence.
